// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed host byte stream to 16-bit data memory loader
module program_loader #(
    parameter logic [7:0] HEADER = 8'hA5,
    parameter int         ADDR_W = 8
) (
    input  logic              ldr_clk,
    input  logic              ldr_rst,
    input  logic [7:0]        ldr_rx_data,
    input  logic              ldr_rx_valid,
    output logic              ldr_rx_ready,
    output logic [ADDR_W-1:0] ldr_mem_addr,
    output logic [15:0]       ldr_mem_data,
    output logic              ldr_mem_wr_en,
    output logic              ldr_word_op,
    output logic              ldr_cpu_hold,
    output logic              ldr_done,
    output logic              ldr_error
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [8:0]        word_cnt;
    logic [7:0]        checksum;
    logic [7:0]        data_hi;
    logic              done_q;
    logic              error_q;
    logic              rx_fire;

    // Handshake and strobes are pure state decodes so rx inputs never reach outputs
    assign ldr_rx_ready  = (state != S_WRITE);
    assign ldr_mem_wr_en = (state == S_WRITE);
    assign ldr_word_op   = 1'b1;
    assign ldr_cpu_hold  = (state != S_DONE);
    assign ldr_done      = done_q;
    assign ldr_error     = error_q;
    assign rx_fire       = ldr_rx_valid && ldr_rx_ready;

    // Frame parser: header, address, length, data pairs with a write cycle each, checksum
    always_ff @(posedge ldr_clk or posedge ldr_rst) begin
        if (ldr_rst) begin
            state        <= S_IDLE;
            addr_q       <= '0;
            word_cnt     <= '0;
            checksum     <= '0;
            data_hi      <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            ldr_mem_addr <= '0;
            ldr_mem_data <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    // Anything other than a header is dropped; status persists until a new frame
                    if (rx_fire && ldr_rx_data == HEADER) begin
                        state   <= S_ADDR;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                    end
                end
                S_ADDR: begin
                    if (rx_fire) begin
                        addr_q <= ADDR_W'(ldr_rx_data);
                        state  <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (rx_fire) begin
                        // A zero count encodes a full 256-word frame
                        word_cnt <= (ldr_rx_data == 8'd0) ? 9'd256 : {1'b0, ldr_rx_data};
                        checksum <= 8'd0;
                        state    <= S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    if (rx_fire) begin
                        data_hi  <= ldr_rx_data;
                        checksum <= checksum + ldr_rx_data;
                        state    <= S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    if (rx_fire) begin
                        // Memory port registers are loaded here so they are stable through WRITE
                        ldr_mem_addr <= addr_q;
                        ldr_mem_data <= {data_hi, ldr_rx_data};
                        checksum     <= checksum + ldr_rx_data;
                        state        <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    addr_q   <= addr_q + 1'b1;
                    word_cnt <= word_cnt - 9'd1;
                    state    <= (word_cnt == 9'd1) ? S_CHECK : S_DATA_HI;
                end
                S_CHECK: begin
                    if (rx_fire) begin
                        if (ldr_rx_data == checksum) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= S_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader
`timescale 1ns/1ps
module tb_program_loader;

    localparam logic [7:0] HDR = 8'hA5;

    logic        ldr_clk;
    logic        ldr_rst;
    logic [7:0]  ldr_rx_data;
    logic        ldr_rx_valid;
    logic        ldr_rx_ready;
    logic [7:0]  ldr_mem_addr;
    logic [15:0] ldr_mem_data;
    logic        ldr_mem_wr_en;
    logic        ldr_word_op;
    logic        ldr_cpu_hold;
    logic        ldr_done;
    logic        ldr_error;

    int checks   = 0;
    int failures = 0;
    time last_edge = 0;

    logic [7:0]  got_addr [$];
    logic [15:0] got_data [$];
    logic [7:0]  spec_bytes [4] = '{8'h12, 8'h34, 8'hAB, 8'hCD};

    typedef struct {
        logic [7:0] start;
        int         n;
        int         pat;
        bit         corrupt;
        bit         gaps;
        logic       exp_done;
        logic       exp_err;
        logic       exp_hold;
    } frame_vec_t;

    program_loader #(.HEADER(HDR), .ADDR_W(8)) dut (
        .ldr_clk      (ldr_clk),
        .ldr_rst      (ldr_rst),
        .ldr_rx_data  (ldr_rx_data),
        .ldr_rx_valid (ldr_rx_valid),
        .ldr_rx_ready (ldr_rx_ready),
        .ldr_mem_addr (ldr_mem_addr),
        .ldr_mem_data (ldr_mem_data),
        .ldr_mem_wr_en(ldr_mem_wr_en),
        .ldr_word_op  (ldr_word_op),
        .ldr_cpu_hold (ldr_cpu_hold),
        .ldr_done     (ldr_done),
        .ldr_error    (ldr_error)
    );

    initial begin
        ldr_clk = 1'b0;
        forever #5 ldr_clk = ~ldr_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: act=%0h req=%0h", name, act, exp);
        end
    endtask

    // Every write strobe is captured; ready must be low and word_op high while it is asserted
    always @(negedge ldr_clk) begin
        if (!ldr_rst && ldr_mem_wr_en === 1'b1) begin
            got_addr.push_back(ldr_mem_addr);
            got_data.push_back(ldr_mem_data);
            check("ready_low_in_write", 32'(ldr_rx_ready), 32'd0);
            check("word_op_in_write", 32'(ldr_word_op), 32'd1);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge ldr_clk);
        ldr_rx_data  = b;
        ldr_rx_valid = 1'b1;
        while (ldr_rx_ready !== 1'b1 && t < 20) begin
            @(negedge ldr_clk);
            t++;
        end
        if (t >= 20) check("ready_timeout", 32'd0, 32'd1);
        @(posedge ldr_clk);
        last_edge = $time;
    endtask

    task automatic gap(input int k);
        @(negedge ldr_clk);
        ldr_rx_valid = 1'b0;
        repeat (k) @(negedge ldr_clk);
    endtask

    // Reference model: frame bytes, expected writes and checksum derived from the frame rules
    task automatic run_frame(input logic [7:0] start, input int n, input int pat,
                             input bit corrupt, input bit gaps, input bit skip_hdr,
                             input logic exp_done, input logic exp_err,
                             input logic exp_hold, input string name);
        logic [7:0] b [$];
        logic [7:0] sum = 8'd0;
        logic [7:0] chk;
        logic [7:0] ea;
        time t0 = 0;
        time t1;
        for (int i = 0; i < 2 * n; i++) begin
            case (pat)
                0:       b.push_back(spec_bytes[i % 4]);
                1:       b.push_back(8'h01);
                default: b.push_back(8'($urandom));
            endcase
            sum = sum + b[i];
        end
        chk = corrupt ? ((sum == 8'd0) ? 8'h01 : 8'h00) : sum;
        got_addr.delete();
        got_data.delete();
        if (!skip_hdr) begin
            send_byte(HDR);
            t0 = last_edge;
        end
        send_byte(start);
        send_byte((n == 256) ? 8'h00 : 8'(n));
        for (int i = 0; i < 2 * n; i++) begin
            send_byte(b[i]);
            if (gaps && $urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
        end
        send_byte(chk);
        t1 = last_edge;
        @(negedge ldr_clk);
        ldr_rx_valid = 1'b0;
        check({name, " done"}, 32'(ldr_done), 32'(exp_done));
        check({name, " error"}, 32'(ldr_error), 32'(exp_err));
        check({name, " hold"}, 32'(ldr_cpu_hold), 32'(exp_hold));
        if (!gaps && !skip_hdr)
            check({name, " cycles"}, 32'((t1 - t0) / 10), 32'(3 * n + 3));
        check({name, " nwrites"}, 32'(got_addr.size()), 32'(n));
        for (int i = 0; i < n && i < got_addr.size(); i++) begin
            ea = start + 8'(i);
            check({name, " addr"}, 32'(got_addr[i]), 32'(ea));
            check({name, " data"}, 32'(got_data[i]), 32'({b[2 * i], b[2 * i + 1]}));
        end
    endtask

    frame_vec_t vecs [5];
    logic [7:0] garbage [3] = '{8'h00, 8'h5A, 8'hFF};

    initial begin
        vecs[0] = '{8'h10, 2,   0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h10, 2,   0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{8'hFF, 1,   2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'hFE, 3,   2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 256, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        ldr_rst      = 1'b1;
        ldr_rx_valid = 1'b0;
        ldr_rx_data  = 8'h00;
        repeat (3) @(negedge ldr_clk);
        ldr_rst = 1'b0;
        @(negedge ldr_clk);
        check("rst ready", 32'(ldr_rx_ready), 32'd1);
        check("rst hold", 32'(ldr_cpu_hold), 32'd1);
        check("rst done", 32'(ldr_done), 32'd0);
        check("rst error", 32'(ldr_error), 32'd0);
        check("rst wr_en", 32'(ldr_mem_wr_en), 32'd0);
        check("rst word_op", 32'(ldr_word_op), 32'd1);
        check("rst mem_addr", 32'(ldr_mem_addr), 32'd0);
        check("rst mem_data", 32'(ldr_mem_data), 32'd0);

        // Non-header bytes in IDLE are absorbed without any visible effect
        got_addr.delete();
        for (int i = 0; i < 3; i++) begin
            send_byte(garbage[i]);
            @(negedge ldr_clk);
            check("garbage ready", 32'(ldr_rx_ready), 32'd1);
            check("garbage hold", 32'(ldr_cpu_hold), 32'd1);
            check("garbage done", 32'(ldr_done), 32'd0);
        end
        check("garbage nwrites", 32'(got_addr.size()), 32'd0);

        for (int v = 0; v < 5; v++)
            run_frame(vecs[v].start, vecs[v].n, vecs[v].pat, vecs[v].corrupt, vecs[v].gaps,
                      1'b0, vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_hold,
                      $sformatf("vec%0d", v));

        // Header after DONE raises hold and clears done in the following cycle
        send_byte(HDR);
        @(negedge ldr_clk);
        ldr_rx_valid = 1'b0;
        check("reload hold", 32'(ldr_cpu_hold), 32'd1);
        check("reload done", 32'(ldr_done), 32'd0);
        run_frame(8'h40, 2, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "reload");

        // Bad checksum, then a header clears the error flag
        run_frame(8'h50, 2, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "bad");
        send_byte(HDR);
        @(negedge ldr_clk);
        ldr_rx_valid = 1'b0;
        check("err clear", 32'(ldr_error), 32'd0);
        check("err clear hold", 32'(ldr_cpu_hold), 32'd1);
        run_frame(8'h60, 1, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "after_err");

        // Reset while the low data byte is being offered must suppress the write
        got_addr.delete();
        got_data.delete();
        send_byte(HDR);
        send_byte(8'h20);
        send_byte(8'h01);
        send_byte(8'h11);
        @(negedge ldr_clk);
        ldr_rx_data  = 8'h22;
        ldr_rx_valid = 1'b1;
        ldr_rst      = 1'b1;
        #1;
        check("midrst wr_en", 32'(ldr_mem_wr_en), 32'd0);
        check("midrst ready", 32'(ldr_rx_ready), 32'd1);
        check("midrst hold", 32'(ldr_cpu_hold), 32'd1);
        @(negedge ldr_clk);
        ldr_rx_valid = 1'b0;
        @(negedge ldr_clk);
        ldr_rst = 1'b0;
        repeat (2) @(negedge ldr_clk);
        check("midrst nwrites", 32'(got_addr.size()), 32'd0);
        check("midrst done", 32'(ldr_done), 32'd0);
        run_frame(8'h30, 3, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "post_rst");

        // Randomized frames with random gaps in valid
        for (int r = 0; r < 6; r++) begin
            logic [7:0] st;
            int  nn;
            bit  bad;
            st  = 8'($urandom);
            nn  = $urandom_range(1, 8);
            bad = ($urandom_range(0, 2) == 0);
            run_frame(st, nn, 2, bad, 1'b1, 1'b0, !bad, bad, bad, $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
